// File: rtl/uz_nn_acc_dl_pkg.sv
// ---------------------------------------------------------------------------
// uz_nn_acc_dl_pkg
// Shared definitions for the NN accelerator deadlock token controller:
//   - dl_state_e : controller FSM states
//   - PROC_ID_W  : process index width for the default process count
//   - id_width() / cnt_width() : width helpers evaluated at elaboration
// No ports (package).
// ---------------------------------------------------------------------------
package uz_nn_acc_dl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONFIRM = 3'd1,
    ORIGIN  = 3'd2,
    TRACE   = 3'd3,
    REPORT  = 3'd4,
    HOLD    = 3'd5
  } dl_state_e;

  localparam int PROC_NUM_DEF = 4;
  localparam int PROC_ID_W    = $clog2(PROC_NUM_DEF);

  // Index width for n processes; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold any value up to and including limit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/uz_nn_acc_dl_prio_enc.sv
// ---------------------------------------------------------------------------
// uz_nn_acc_dl_prio_enc
// Lowest-index priority encoder.
// Ports:
//   vec   in  N      request vector
//   idx   out IDX_W  index of the lowest set bit (0 when none set)
//   valid out 1      at least one bit of vec is set
// ---------------------------------------------------------------------------
module uz_nn_acc_dl_prio_enc
  import uz_nn_acc_dl_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/uz_nn_acc_hls_deadlock_token_ctrl.sv
// ---------------------------------------------------------------------------
// uz_nn_acc_hls_deadlock_token_ctrl
// Central deadlock controller for the dataflow detect units. Debounces a
// candidate deadlock, strobes its origin, follows the token around the
// dependency cycle, clears the token on return and latches a sticky report.
// Ports:
//   clock, reset       clock and synchronous active-high reset
//   dl_detect_vec      per-unit dl_detect_out
//   token_ret_vec      per-unit "token currently here"
//   clear_flag         software clear of the sticky report (HOLD only)
//   dl_detect_glob     broadcast dl_detect_in to every unit
//   origin_vec         one-hot origin strobe (ORIGIN state)
//   token_clear_vec    one-hot token clear (TRACE, same cycle as return)
//   deadlock_flag      sticky report valid
//   deadlock_proc_id   origin process of the reported cycle
//   cycle_path         bitmap of processes visited by the token
//   irq                one-cycle pulse when the report is loaded
// ---------------------------------------------------------------------------
module uz_nn_acc_hls_deadlock_token_ctrl
  import uz_nn_acc_dl_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int CONFIRM_CYCLES = 16,
  parameter int TOKEN_TIMEOUT  = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PROC_NUM-1:0]           dl_detect_vec,
  input  logic [PROC_NUM-1:0]           token_ret_vec,
  input  logic                          clear_flag,
  output logic                          dl_detect_glob,
  output logic [PROC_NUM-1:0]           origin_vec,
  output logic [PROC_NUM-1:0]           token_clear_vec,
  output logic                          deadlock_flag,
  output logic [id_width(PROC_NUM)-1:0] deadlock_proc_id,
  output logic [PROC_NUM-1:0]           cycle_path,
  output logic                          irq
);

  localparam int ID_W  = id_width(PROC_NUM);
  localparam int CNT_W = cnt_width(CONFIRM_CYCLES);
  localparam int TMR_W = cnt_width(TOKEN_TIMEOUT);

  localparam logic [PROC_NUM-1:0] ONE_HOT0 = PROC_NUM'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0]    TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TOKEN_TIMEOUT - 1);

  dl_state_e             state_r, state_s;
  logic [ID_W-1:0]       p_r, p_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [TMR_W-1:0]      timer_r, timer_s;
  logic [PROC_NUM-1:0]   path_r, path_s;
  logic                  flag_r, flag_s;
  logic [ID_W-1:0]       id_r, id_s;
  logic [PROC_NUM-1:0]   cpath_r, cpath_s;

  logic                  glob_s;
  logic [PROC_NUM-1:0]   origin_s;
  logic [PROC_NUM-1:0]   tclr_s;
  logic                  irq_s;

  logic [ID_W-1:0]       cand_idx_s;
  logic                  cand_valid_s;

  uz_nn_acc_dl_prio_enc #(
    .N     (PROC_NUM),
    .IDX_W (ID_W)
  ) u_prio_enc (
    .vec   (dl_detect_vec),
    .idx   (cand_idx_s),
    .valid (cand_valid_s)
  );

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      p_r     <= '0;
      cnt_r   <= '0;
      timer_r <= '0;
      path_r  <= '0;
      flag_r  <= 1'b0;
      id_r    <= '0;
      cpath_r <= '0;
    end else begin
      state_r <= state_s;
      p_r     <= p_s;
      cnt_r   <= cnt_s;
      timer_r <= timer_s;
      path_r  <= path_s;
      flag_r  <= flag_s;
      id_r    <= id_s;
      cpath_r <= cpath_s;
    end
  end

  // Next-state, datapath updates and state-decoded strobes.
  always_comb begin
    state_s  = state_r;
    p_s      = p_r;
    cnt_s    = cnt_r;
    timer_s  = timer_r;
    path_s   = path_r;
    flag_s   = flag_r;
    id_s     = id_r;
    cpath_s  = cpath_r;
    glob_s   = 1'b0;
    origin_s = '0;
    tclr_s   = '0;
    irq_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (cand_valid_s) begin
          p_s     = cand_idx_s;
          cnt_s   = '0;
          state_s = CONFIRM;
        end else begin
          state_s = IDLE;
        end
      end

      CONFIRM: begin
        // Only the latched candidate matters; other units may come and go.
        if (!dl_detect_vec[p_r]) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ORIGIN;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ORIGIN: begin
        glob_s   = 1'b1;
        origin_s = ONE_HOT0 << p_r;
        path_s   = ONE_HOT0 << p_r;
        timer_s  = '0;
        state_s  = TRACE;
      end

      TRACE: begin
        glob_s = 1'b1;
        path_s = path_r | token_ret_vec;
        // Return is checked first so it wins over a same-cycle timeout.
        if (token_ret_vec[p_r]) begin
          tclr_s  = ONE_HOT0 << p_r;
          state_s = REPORT;
        end else if (timer_r == TMR_LAST) begin
          path_s  = '0;
          state_s = IDLE;
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end

      REPORT: begin
        glob_s  = 1'b1;
        irq_s   = 1'b1;
        flag_s  = 1'b1;
        id_s    = p_r;
        cpath_s = path_r;
        state_s = HOLD;
      end

      HOLD: begin
        // Keeping dl_detect_glob high freezes every unit's dependency state.
        glob_s = 1'b1;
        if (clear_flag) begin
          flag_s  = 1'b0;
          id_s    = '0;
          cpath_s = '0;
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign dl_detect_glob   = glob_s;
  assign origin_vec       = origin_s;
  assign token_clear_vec  = tclr_s;
  assign irq              = irq_s;
  assign deadlock_flag    = flag_r;
  assign deadlock_proc_id = id_r;
  assign cycle_path       = cpath_r;

endmodule

// File: tb/tb_uz_nn_acc_hls_deadlock_token_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for uz_nn_acc_hls_deadlock_token_ctrl with
// PROC_NUM=4, CONFIRM_CYCLES=4, TOKEN_TIMEOUT=8. Each step drives inputs on
// the falling edge, queues the outputs expected for that cycle and checks
// them 1 ns later.
// ---------------------------------------------------------------------------
module tb_uz_nn_acc_hls_deadlock_token_ctrl;

  typedef struct packed {
    logic       glob;
    logic [3:0] origin;
    logic [3:0] tclr;
    logic       irq;
    logic       flag;
    logic [1:0] id;
    logic [3:0] path;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dl_detect_vec;
  logic [3:0] token_ret_vec;
  logic       clear_flag;
  logic       dl_detect_glob;
  logic [3:0] origin_vec;
  logic [3:0] token_clear_vec;
  logic       deadlock_flag;
  logic [1:0] deadlock_proc_id;
  logic [3:0] cycle_path;
  logic       irq;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step_no    = 0;

  uz_nn_acc_hls_deadlock_token_ctrl #(
    .PROC_NUM       (4),
    .CONFIRM_CYCLES (4),
    .TOKEN_TIMEOUT  (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dl_detect_vec    (dl_detect_vec),
    .token_ret_vec    (token_ret_vec),
    .clear_flag       (clear_flag),
    .dl_detect_glob   (dl_detect_glob),
    .origin_vec       (origin_vec),
    .token_clear_vec  (token_clear_vec),
    .deadlock_flag    (deadlock_flag),
    .deadlock_proc_id (deadlock_proc_id),
    .cycle_path       (cycle_path),
    .irq              (irq)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic g, input logic [3:0] o, input logic [3:0] t,
                              input logic i, input logic f, input logic [1:0] id,
                              input logic [3:0] p);
    exp_t e;
    e.glob = g; e.origin = o; e.tclr = t; e.irq = i;
    e.flag = f; e.id = id; e.path = p;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL step%0d %s: observed %0h expected %0h", step_no, tag, obs, exp);
    end
  endtask

  task automatic check_front();
    exp_t x;
    x = sb_q.pop_front();
    chk("dl_detect_glob",   {7'd0, dl_detect_glob},   {7'd0, x.glob});
    chk("origin_vec",       {4'd0, origin_vec},       {4'd0, x.origin});
    chk("token_clear_vec",  {4'd0, token_clear_vec},  {4'd0, x.tclr});
    chk("irq",              {7'd0, irq},              {7'd0, x.irq});
    chk("deadlock_flag",    {7'd0, deadlock_flag},    {7'd0, x.flag});
    chk("deadlock_proc_id", {6'd0, deadlock_proc_id}, {6'd0, x.id});
    chk("cycle_path",       {4'd0, cycle_path},       {4'd0, x.path});
  endtask

  task automatic step(input logic [3:0] dl, input logic [3:0] tr, input logic clr,
                      input logic rst, input exp_t e);
    @(negedge clock);
    dl_detect_vec = dl;
    token_ret_vec = tr;
    clear_flag    = clr;
    reset         = rst;
    sb_q.push_back(e);
    step_no++;
    #1;
    check_front();
  endtask

  initial begin
    exp_t z;
    exp_t g;
    z = mk(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);
    g = mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0);

    reset = 1'b1; dl_detect_vec = 4'h0; token_ret_vec = 4'h0; clear_flag = 1'b0;
    repeat (2) @(posedge clock);
    step(4'h0, 4'h0, 1'b0, 1'b1, z);               // reset state
    step(4'h0, 4'h0, 1'b0, 1'b0, z);

    // Glitch rejection: candidate 2 high for two cycles only.
    step(4'b0100, 4'h0, 1'b0, 1'b0, z);            // IDLE samples
    step(4'b0100, 4'h0, 1'b0, 1'b0, z);            // CONFIRM
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);            // CONFIRM drops -> IDLE
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);

    // Full detection, candidate 1; clear_flag pulsed in CONFIRM is ignored.
    step(4'b0010, 4'h0, 1'b0, 1'b0, z);            // t: IDLE
    for (int i = 0; i < 4; i++) step(4'b0010, 4'h0, (i == 1), 1'b0, z);
    step(4'b0010, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'b0010, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0)); // t+5
    step(4'b0010, 4'b0100, 1'b0, 1'b0, g);
    step(4'b0010, 4'b1000, 1'b0, 1'b0, g);
    step(4'b0010, 4'b0010, 1'b0, 1'b0, mk(1'b1, 4'h0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'h0));
    step(4'b0000, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0));    // REPORT
    step(4'b0000, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'b1110)); // HOLD
    step(4'b0000, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'b1110));
    step(4'b0000, 4'h0, 1'b1, 1'b0, mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 4'b1110));
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);            // cleared, back in IDLE

    // Simultaneous candidates 1 and 3 -> origin 1; token then lost.
    step(4'b1010, 4'h0, 1'b0, 1'b0, z);
    for (int i = 0; i < 4; i++) step(4'b1010, 4'h0, 1'b0, 1'b0, z);
    step(4'b1010, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'b0010, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0));
    for (int i = 0; i < 8; i++) step(4'b0000, 4'h0, 1'b0, 1'b0, g);
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);            // timed out, no report
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);

    // Return in the final TRACE cycle wins over timeout; reset drops pending report.
    step(4'b0001, 4'h0, 1'b0, 1'b0, z);
    for (int i = 0; i < 4; i++) step(4'b0001, 4'h0, 1'b0, 1'b0, z);
    step(4'b0001, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'b0001, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0));
    for (int i = 0; i < 7; i++) step(4'b0000, 4'h0, 1'b0, 1'b0, g);
    step(4'b0000, 4'b0001, 1'b0, 1'b0, mk(1'b1, 4'h0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'h0));
    step(4'b0000, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0));
    step(4'b0000, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'b0001));
    step(4'b0000, 4'h0, 1'b0, 1'b1, mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 4'b0001));
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);

    // Reset while tracing (candidate 2).
    step(4'b0100, 4'h0, 1'b0, 1'b0, z);
    for (int i = 0; i < 4; i++) step(4'b0100, 4'h0, 1'b0, 1'b0, z);
    step(4'b0100, 4'h0, 1'b0, 1'b0, mk(1'b1, 4'b0100, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0));
    step(4'b0000, 4'b1000, 1'b0, 1'b0, g);
    step(4'b0000, 4'h0, 1'b0, 1'b1, g);            // reset sampled in TRACE
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);
    step(4'b0000, 4'h0, 1'b0, 1'b0, z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
